display_control: RTL and testbench
==================================

Name: display_control

Overview:
- Time-multiplexed driver for a 4-digit seven-segment display.
- Takes a 16-bit value (four 4-bit nibbles) and cycles through the digits.
- Each period it drives one active-low digit enable plus that digit's 4-bit value to a downstream hex-to-segment decoder.
- Sits between the datapath (value source) and the segment decoder / board anode pins.

Parameters:
- CYCLES_PER_DIGIT, default 1: clk cycles each digit stays selected before advancing. Must be >= 1. Board builds override, e.g. 100000 for about a 1 ms digit period at 100 MHz.
- CNT_WIDTH, default 17: width of the internal refresh counter. Must satisfy 2^CNT_WIDTH >= CYCLES_PER_DIGIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- display_select  input  16  value to display. Nibble [3:0] is digit 0 (rightmost), [7:4] digit 1, [11:8] digit 2, [15:12] digit 3. May change on any cycle.
- digit_value  output  4  nibble of the currently selected digit (registered).
- digit_select  output  4  one-hot-low digit enable, bit i low means digit i is on (registered).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, resetn).
- State:
  - refresh counter cnt, CNT_WIDTH bits.
  - digit index idx, 2 bits.
  - registered outputs digit_value and digit_select.
- Reset (resetn=0, asynchronous, any time including mid-scan):
  - cnt=0, idx=0.
  - digit_value=4'h0.
  - digit_select=4'b1111 (all digits off).
  - Held for as long as resetn is low.
- Refresh tick: on each rising edge with resetn=1:
  - if cnt==CYCLES_PER_DIGIT-1, then cnt<=0 and idx<=idx+1 (wraps 3 -> 0);
  - otherwise cnt<=cnt+1.
  - With CYCLES_PER_DIGIT=1, idx advances every cycle.
- Output update: on every rising edge with resetn=1, both outputs are driven from the pre-edge values of idx and display_select:
  - digit_select <= ~(4'b0001 << idx), i.e. 1110, 1101, 1011, 0111 for idx 0..3.
  - digit_value <= display_select[4*idx +: 4].
- Latency:
  - Outputs lag idx and display_select by exactly 1 cycle.
  - A change on display_select appears on digit_value at the next edge where its digit is selected; there is no capture or hold of the full 16-bit word.
- Scan order: digit 0, 1, 2, 3, 0, ... Each digit is active for exactly CYCLES_PER_DIGIT consecutive cycles.
- Invariant: after the first post-reset edge, digit_select has exactly one zero bit at all times. No glitch states, because outputs are registered.
- First edge after reset release: digit_select=1110 and digit_value=display_select[3:0].
- No handshake, no enable input; the scan free-runs whenever out of reset.
- Reset asserted mid-scan: outputs return to 1111/0 immediately, without waiting for a clock edge. The scan restarts at digit 0 after release.

Test Plan:
- Reset: resetn=0 with clocks running, display_select=16'h0F59 -> digit_select=1111 and digit_value=0 throughout, including immediately (asynchronously) on assertion.
- Scan, CYCLES_PER_DIGIT=1: release resetn with display_select=16'h0F59 held -> edges 1..5 give (digit_select, digit_value) = (1110,9), (1101,5), (1011,F), (0111,0), (1110,9).
- Live update: display_select increments every 2 cycles from 16'h0F59 -> each cycle, digit_value equals the selected nibble of the display_select value sampled at that edge. Digit 0 shows 9, B, D, ... on successive visits.
- Dwell, CYCLES_PER_DIGIT=3: display_select=16'h1234 -> digit_value is 4,4,4,3,3,3,2,2,2,1,1,1, then wraps to 4. digit_select is stable within each group of 3.
- Mid-scan reset: assert resetn while digit 2 is active -> outputs go to 1111/0 without a clock edge. After release, the first edge shows digit 0 (1110).
- One-hot check: random display_select over 1000 cycles -> digit_select always has exactly one zero bit, and idx wraps cleanly from 3 to 0.

Source files
------------

// File: rtl/display_control_if.sv
// Signal bundle between the value source and the digit-scan driver.
// The driver side uses the slave modport.
interface display_control_if;
    logic [15:0] display_select;
    logic [3:0]  digit_value;
    logic [3:0]  digit_select;

    modport master (output display_select, input digit_value, input digit_select);
    modport slave  (input display_select, output digit_value, output digit_select);
endinterface

// File: rtl/display_control.sv
// Time-multiplexed 4-digit seven-segment scan driver.
// Each digit is held for CYCLES_PER_DIGIT clocks, and both outputs are registered.
module display_control #(
    parameter int CYCLES_PER_DIGIT = 1,
    parameter int CNT_WIDTH        = 17
) (
    input logic              clk,
    input logic              resetn,
    display_control_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CYCLES_PER_DIGIT - 1);

    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs are driven from the idx value before the edge, so they trail the scan index by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.digit_value  <= 4'h0;
            bus.digit_select <= 4'b1111;
        end else begin
            bus.digit_value  <= bus.display_select[{idx, 2'b00} +: 4];
            bus.digit_select <= ~(4'b0001 << idx);
        end
    end
endmodule

// File: tb/tb_display_control.sv
// Directed checks of the digit scan driver, using two instances:
// dut1 runs with one cycle per digit and dut3 with three cycles per digit.
module tb_display_control;
    logic clk;
    logic r1;
    logic r3;
    int   checks;
    int   failures;

    display_control_if bus1 ();
    display_control_if bus3 ();

    display_control #(.CYCLES_PER_DIGIT(1), .CNT_WIDTH(17)) dut1 (.clk(clk), .resetn(r1), .bus(bus1));
    display_control #(.CYCLES_PER_DIGIT(3), .CNT_WIDTH(4))  dut3 (.clk(clk), .resetn(r3), .bus(bus3));

    typedef struct {
        logic [15:0] ds;
        logic [3:0]  sel;
        logic [3:0]  val;
    } vec_t;

    vec_t scan_tab[5];
    vec_t dwell_tab[13];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] ds;
        logic [3:0]  esel;
        int          pos;
        checks   = 0;
        failures = 0;

        scan_tab[0] = '{16'h0F59, 4'b1110, 4'h9};
        scan_tab[1] = '{16'h0F59, 4'b1101, 4'h5};
        scan_tab[2] = '{16'h0F59, 4'b1011, 4'hF};
        scan_tab[3] = '{16'h0F59, 4'b0111, 4'h0};
        scan_tab[4] = '{16'h0F59, 4'b1110, 4'h9};
        for (int i = 0; i < 13; i++) begin
            dwell_tab[i].ds = 16'h1234;
        end
        dwell_tab[0].sel  = 4'b1110; dwell_tab[0].val  = 4'h4;
        dwell_tab[1].sel  = 4'b1110; dwell_tab[1].val  = 4'h4;
        dwell_tab[2].sel  = 4'b1110; dwell_tab[2].val  = 4'h4;
        dwell_tab[3].sel  = 4'b1101; dwell_tab[3].val  = 4'h3;
        dwell_tab[4].sel  = 4'b1101; dwell_tab[4].val  = 4'h3;
        dwell_tab[5].sel  = 4'b1101; dwell_tab[5].val  = 4'h3;
        dwell_tab[6].sel  = 4'b1011; dwell_tab[6].val  = 4'h2;
        dwell_tab[7].sel  = 4'b1011; dwell_tab[7].val  = 4'h2;
        dwell_tab[8].sel  = 4'b1011; dwell_tab[8].val  = 4'h2;
        dwell_tab[9].sel  = 4'b0111; dwell_tab[9].val  = 4'h1;
        dwell_tab[10].sel = 4'b0111; dwell_tab[10].val = 4'h1;
        dwell_tab[11].sel = 4'b0111; dwell_tab[11].val = 4'h1;
        dwell_tab[12].sel = 4'b1110; dwell_tab[12].val = 4'h4;

        r1 = 1'b1;
        r3 = 1'b1;
        bus1.display_select = 16'h0F59;
        bus3.display_select = 16'h1234;

        // Assert reset before any clock edge so the reset values can only come from the asynchronous path.
        #2 r1 = 1'b0; r3 = 1'b0;
        #1;
        chk("async_reset_sel", bus1.digit_select, 4'b1111);
        chk("async_reset_val", bus1.digit_value, 4'h0);
        chk("async_reset_sel3", bus3.digit_select, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_held_sel", bus1.digit_select, 4'b1111);
            chk("reset_held_val", bus1.digit_value, 4'h0);
        end

        r1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus1.display_select = scan_tab[i].ds;
            @(negedge clk);
            chk($sformatf("scan%0d_sel", i), bus1.digit_select, scan_tab[i].sel);
            chk($sformatf("scan%0d_val", i), bus1.digit_value, scan_tab[i].val);
        end

        // Advance two more edges so that digit 2 is the active digit, then assert reset between edges.
        repeat (2) @(negedge clk);
        chk("pre_midreset_sel", bus1.digit_select, 4'b1011);
        r1 = 1'b0;
        #1;
        chk("midreset_sel", bus1.digit_select, 4'b1111);
        chk("midreset_val", bus1.digit_value, 4'h0);
        @(negedge clk);
        chk("midreset_hold_sel", bus1.digit_select, 4'b1111);
        r1 = 1'b1;
        @(negedge clk);
        chk("post_release_sel", bus1.digit_select, 4'b1110);
        chk("post_release_val", bus1.digit_value, 4'h9);

        // Live update: the value steps up every 2 cycles, so each visit to digit 0 shows 9, B, D, ...
        r1 = 1'b0;
        @(negedge clk);
        r1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ds = 16'h0F59 + 16'(k / 2);
            bus1.display_select = ds;
            @(negedge clk);
            esel = 4'b1111;
            esel[k % 4] = 1'b0;
            chk($sformatf("live%0d_sel", k), bus1.digit_select, esel);
            chk($sformatf("live%0d_val", k), bus1.digit_value, ds[4*(k%4) +: 4]);
        end

        pos = 0;
        for (int k = 0; k < 1000; k++) begin
            ds = 16'($urandom);
            bus1.display_select = ds;
            @(negedge clk);
            esel = 4'b1111;
            esel[pos] = 1'b0;
            chk("rand_onehot", 4'($countones(~bus1.digit_select)), 4'd1);
            chk("rand_sel", bus1.digit_select, esel);
            chk("rand_val", bus1.digit_value, ds[4*pos +: 4]);
            pos = (pos + 1) % 4;
        end

        r3 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bus3.display_select = dwell_tab[i].ds;
            @(negedge clk);
            chk($sformatf("dwell%0d_sel", i), bus3.digit_select, dwell_tab[i].sel);
            chk($sformatf("dwell%0d_val", i), bus3.digit_value, dwell_tab[i].val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
